// File: rtl/core_seq.sv
// core_seq: multi-cycle instruction sequencer for the single-issue RV32 core.
// Steps the PC once per retired or trapped instruction and runs the fetch/data handshakes.
`ifndef PC_SNPC
`define PC_SNPC  3'd0
`define PC_J_pc  3'd1
`define PC_J_rs1 3'd2
`define PC_B     3'd3
`define PC_B_inv 3'd4
`define PC_EPC   3'd5
`define PC_TRAP  3'd6
`endif

module core_seq #(
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_req_valid,
    input  logic        if_req_ready,
    input  logic        if_rsp_valid,
    input  logic        if_rsp_err,
    input  logic [2:0]  dec_pc_ctrl,
    input  logic        dec_is_mem,
    input  logic        dec_is_store,
    input  logic        dec_illegal,
    input  logic        dec_ecall,
    input  logic        dec_mret,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    input  logic        lsu_rsp_err,
    input  logic        irq_pending,
    input  logic        irq_en,
    output logic [2:0]  pc_ctrl,
    output logic        inst_en,
    output logic        rf_we_en,
    output logic        retire,
    output logic        trap_take,
    output logic [4:0]  trap_cause,
    output logic        mret_take,
    output logic [31:0] instret
);
    // The one encoding left free by the PC_* set; the PC register treats it as hold.
    localparam logic [2:0] PC_HOLD = 3'd7;

    typedef enum logic [2:0] {
        S_START, S_FETCH_REQ, S_FETCH_WAIT, S_EXEC,
        S_MEM_REQ, S_MEM_WAIT, S_COMMIT, S_TRAP
    } state_t;

    state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_if_req_valid;
    logic        r_lsu_req_valid;
    logic [2:0]  r_pc_ctrl;
    logic        r_rf_we_en;
    logic        r_retire;
    logic        r_trap_take;
    logic [4:0]  r_trap_cause;
    logic        r_mret_take;
    logic [31:0] r_instret;

    logic [CNT_W-1:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_go_trap;
    logic        w_go_commit;
    logic [4:0]  w_cause;

    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (BUS_TIMEOUT != 0) && (w_cnt_inc == CNT_W'(BUS_TIMEOUT));

    // Instruction register must capture on the same edge the fetch data is presented.
    assign inst_en = (r_state == S_FETCH_WAIT) && if_rsp_valid && !if_rsp_err;

    always_comb begin
        w_go_trap   = 1'b0;
        w_go_commit = 1'b0;
        w_cause     = 5'd0;
        case (r_state)
            S_START: begin
                if (irq_pending && irq_en) begin
                    w_go_trap = 1'b1;
                    w_cause   = 5'b1_1011;
                end
            end
            S_FETCH_WAIT: begin
                if (if_rsp_valid ? if_rsp_err : w_timeout) begin
                    w_go_trap = 1'b1;
                    w_cause   = 5'b0_0001;
                end
            end
            S_EXEC: begin
                if (dec_illegal) begin
                    w_go_trap = 1'b1;
                    w_cause   = 5'b0_0010;
                end else if (dec_ecall) begin
                    w_go_trap = 1'b1;
                    w_cause   = 5'b0_1011;
                end else if (!dec_is_mem) begin
                    w_go_commit = 1'b1;
                end
            end
            S_MEM_WAIT: begin
                // A response in the timeout cycle wins over the timeout.
                if (lsu_rsp_valid ? lsu_rsp_err : w_timeout) begin
                    w_go_trap = 1'b1;
                    w_cause   = dec_is_store ? 5'b0_0111 : 5'b0_0101;
                end else if (lsu_rsp_valid) begin
                    w_go_commit = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_START;
            r_cnt           <= '0;
            r_if_req_valid  <= 1'b0;
            r_lsu_req_valid <= 1'b0;
            r_pc_ctrl       <= PC_HOLD;
            r_rf_we_en      <= 1'b0;
            r_retire        <= 1'b0;
            r_trap_take     <= 1'b0;
            r_trap_cause    <= 5'd0;
            r_mret_take     <= 1'b0;
            r_instret       <= 32'd0;
        end else begin
            r_pc_ctrl   <= PC_HOLD;
            r_rf_we_en  <= 1'b0;
            r_retire    <= 1'b0;
            r_trap_take <= 1'b0;
            r_mret_take <= 1'b0;
            case (r_state)
                S_START: begin
                    r_state        <= S_FETCH_REQ;
                    r_if_req_valid <= 1'b1;
                end
                S_FETCH_REQ: begin
                    if (if_req_ready) begin
                        r_if_req_valid <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    if (if_rsp_valid) r_state <= S_EXEC;
                    else              r_cnt   <= w_cnt_inc;
                end
                S_EXEC: begin
                    if (dec_is_mem) begin
                        r_state         <= S_MEM_REQ;
                        r_lsu_req_valid <= 1'b1;
                    end
                end
                S_MEM_REQ: begin
                    if (lsu_req_ready) begin
                        r_lsu_req_valid <= 1'b0;
                        r_cnt           <= '0;
                        r_state         <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (!lsu_rsp_valid) r_cnt <= w_cnt_inc;
                end
                default: r_state <= S_START;
            endcase
            // Trap/commit entry overrides whatever the plain transition above chose.
            if (w_go_trap) begin
                r_state         <= S_TRAP;
                r_if_req_valid  <= 1'b0;
                r_lsu_req_valid <= 1'b0;
                r_trap_take     <= 1'b1;
                r_trap_cause    <= w_cause;
                r_pc_ctrl       <= `PC_TRAP;
            end else if (w_go_commit) begin
                r_state     <= S_COMMIT;
                r_pc_ctrl   <= dec_mret ? `PC_EPC : dec_pc_ctrl;
                r_retire    <= 1'b1;
                r_rf_we_en  <= !dec_mret;
                r_mret_take <= dec_mret;
                r_instret   <= r_instret + 32'd1;
            end
        end
    end

    assign if_req_valid  = r_if_req_valid;
    assign lsu_req_valid = r_lsu_req_valid;
    assign pc_ctrl       = r_pc_ctrl;
    assign rf_we_en      = r_rf_we_en;
    assign retire        = r_retire;
    assign trap_take     = r_trap_take;
    assign trap_cause    = r_trap_cause;
    assign mret_take     = r_mret_take;
    assign instret       = r_instret;

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq with delay-programmable fetch/data bus responders.
module tb_core_seq;
    localparam int TO = 4;
    localparam logic [2:0] PC_SNPC = 3'd0, PC_J_PC = 3'd1, PC_J_RS1 = 3'd2, PC_B = 3'd3,
                           PC_B_INV = 3'd4, PC_EPC = 3'd5, PC_TRAP = 3'd6, PC_HOLD = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req_valid;
    logic        if_req_ready = 1'b0;
    logic        if_rsp_valid = 1'b0;
    logic        if_rsp_err = 1'b0;
    logic [2:0]  dec_pc_ctrl = 3'd0;
    logic        dec_is_mem = 1'b0, dec_is_store = 1'b0, dec_illegal = 1'b0;
    logic        dec_ecall = 1'b0, dec_mret = 1'b0;
    logic        lsu_req_valid;
    logic        lsu_req_ready = 1'b0;
    logic        lsu_rsp_valid = 1'b0;
    logic        lsu_rsp_err = 1'b0;
    logic        lsu_rsp_force = 1'b0;
    logic        lsu_rsp_v_dut;
    logic        irq_pending = 1'b0, irq_en = 1'b0;
    logic [2:0]  pc_ctrl;
    logic        inst_en, rf_we_en, retire, trap_take, mret_take;
    logic [4:0]  trap_cause;
    logic [31:0] instret;

    assign lsu_rsp_v_dut = lsu_rsp_valid | lsu_rsp_force;

    core_seq #(.BUS_TIMEOUT(TO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_err(if_rsp_err),
        .dec_pc_ctrl(dec_pc_ctrl), .dec_is_mem(dec_is_mem), .dec_is_store(dec_is_store),
        .dec_illegal(dec_illegal), .dec_ecall(dec_ecall), .dec_mret(dec_mret),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_rsp_valid(lsu_rsp_v_dut), .lsu_rsp_err(lsu_rsp_err),
        .irq_pending(irq_pending), .irq_en(irq_en),
        .pc_ctrl(pc_ctrl), .inst_en(inst_en), .rf_we_en(rf_we_en), .retire(retire),
        .trap_take(trap_take), .trap_cause(trap_cause), .mret_take(mret_take),
        .instret(instret)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        trap;
        logic [4:0]  cause;
        logic [2:0]  pc;
        logic        rfwe;
        logic        mret;
        int          lat;
        logic [31:0] instret;
    } exp_t;

    exp_t sbq[$];

    // bus responder configuration, written by stimulus tasks
    int   if_rdy_dly = 0, if_rsp_dly = 0, lsu_rdy_dly = 0, lsu_rsp_dly = 0;
    logic if_err_cfg = 1'b0, lsu_err_cfg = 1'b0;

    int   cyc = 0, last_evt = -1, evt_cnt = 0;
    int   if_wait = 0, if_rsp_cnt = 0, lsu_wait = 0, lsu_rsp_cnt = 0;
    logic if_pend = 1'b0, lsu_pend = 1'b0;
    logic if_v_prev = 1'b0, lsu_v_prev = 1'b0;
    int   lsu_vld_run = 0, lsu_vld_last = 0, if_vld_total = 0, lsu_acc_cnt = 0;
    logic [31:0] exp_instret = 0;

    // Monitor + bus responders, all evaluated away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cyc = 0; last_evt = -1;
            if_pend = 0; lsu_pend = 0; if_wait = 0; lsu_wait = 0; lsu_vld_run = 0;
            if_req_ready = 0; if_rsp_valid = 0; if_rsp_err = 0;
            lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
            if_v_prev = 0; lsu_v_prev = 0;
        end else begin
            if (retire || trap_take) begin
                evt_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("trap_take", {31'd0, trap_take}, {31'd0, e.trap});
                    chk("retire", {31'd0, retire}, {31'd0, !e.trap});
                    chk("pc_ctrl", {29'd0, pc_ctrl}, {29'd0, e.pc});
                    chk("rf_we_en", {31'd0, rf_we_en}, {31'd0, e.rfwe});
                    chk("mret_take", {31'd0, mret_take}, {31'd0, e.mret});
                    chk("latency", cyc - last_evt, e.lat);
                    chk("instret", instret, e.instret);
                    if (e.trap) chk("trap_cause", {27'd0, trap_cause}, {27'd0, e.cause});
                end
                last_evt = cyc;
            end else begin
                chk("pc_hold", {29'd0, pc_ctrl}, {29'd0, PC_HOLD});
                chk("idle_strobes", {30'd0, rf_we_en, mret_take}, 32'd0);
            end
            cyc++;

            if (if_v_prev && !if_req_ready) chk("if_valid_stable", {31'd0, if_req_valid}, 32'd1);
            if (lsu_v_prev && !lsu_req_ready) chk("lsu_valid_stable", {31'd0, lsu_req_valid}, 32'd1);
            if_v_prev = if_req_valid;
            lsu_v_prev = lsu_req_valid;

            if_req_ready = 0; if_rsp_valid = 0; if_rsp_err = 0;
            if (if_pend) begin
                if (if_rsp_cnt == if_rsp_dly) begin
                    if_rsp_valid = 1; if_rsp_err = if_err_cfg; if_pend = 0;
                end else if_rsp_cnt++;
            end
            if (if_req_valid) begin
                if_vld_total++;
                if (if_wait >= if_rdy_dly) begin
                    if_req_ready = 1; if_pend = 1; if_rsp_cnt = 0; if_wait = 0;
                end else if_wait++;
            end

            lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
            if (lsu_pend) begin
                if (lsu_rsp_cnt == lsu_rsp_dly) begin
                    lsu_rsp_valid = 1; lsu_rsp_err = lsu_err_cfg; lsu_pend = 0;
                end else lsu_rsp_cnt++;
            end
            if (lsu_req_valid) begin
                lsu_vld_run++;
                if (lsu_wait >= lsu_rdy_dly) begin
                    lsu_req_ready = 1; lsu_pend = 1; lsu_rsp_cnt = 0; lsu_wait = 0;
                    lsu_vld_last = lsu_vld_run; lsu_vld_run = 0; lsu_acc_cnt++;
                end else lsu_wait++;
            end
        end
    end

    task automatic wait_evt(input string name, input logic irq_mid);
        int start;
        start = evt_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (irq_mid && i == 0) begin irq_pending = 1; irq_en = 1; end
            if (evt_cnt != start) return;
        end
        chk({name, "_evt_timeout"}, 32'd0, 32'd1);
        sbq.delete();
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_pc_hold"}, {29'd0, pc_ctrl}, {29'd0, PC_HOLD});
        chk({name, "_valids"}, {30'd0, if_req_valid, lsu_req_valid}, 32'd0);
        chk({name, "_strobes"}, {27'd0, retire, trap_take, rf_we_en, mret_take, inst_en}, 32'd0);
        chk({name, "_instret"}, instret, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        sbq.delete();
        exp_instret = 0;
        rst_n = 1;
    endtask

    // Called in the START cycle of the instruction; returns in the next START cycle.
    task automatic run_instr(input string name, input logic [2:0] pcc, input logic mem,
                             input logic st, input logic ill, input logic ec, input logic mr,
                             input int ifr, input int ifd, input logic ife,
                             input int lr, input int ld, input logic le, input logic irq_mid);
        exp_t e;
        int   lat;
        logic reach_mem;
        dec_pc_ctrl = pcc; dec_is_mem = mem; dec_is_store = st;
        dec_illegal = ill; dec_ecall = ec; dec_mret = mr;
        if_rdy_dly = ifr; if_rsp_dly = ifd; if_err_cfg = ife;
        lsu_rdy_dly = lr; lsu_rsp_dly = ld; lsu_err_cfg = le;
        e.trap = 0; e.cause = 5'd0; reach_mem = 0;
        lat = 2 + ifr + ((ifd < TO) ? ifd + 1 : TO);
        if (ifd >= TO || ife) begin
            e.trap = 1; e.cause = 5'b0_0001;
        end else begin
            lat += 1;
            if (ill) begin e.trap = 1; e.cause = 5'b0_0010; end
            else if (ec) begin e.trap = 1; e.cause = 5'b0_1011; end
            else if (mem) begin
                reach_mem = 1;
                lat += 1 + lr + ((ld < TO) ? ld + 1 : TO);
                if (ld >= TO || le) begin
                    e.trap = 1; e.cause = st ? 5'b0_0111 : 5'b0_0101;
                end
            end
        end
        lat += 1;
        if (e.trap) begin
            e.pc = PC_TRAP; e.rfwe = 0; e.mret = 0;
        end else begin
            exp_instret = exp_instret + 1;
            e.pc = mr ? PC_EPC : pcc; e.rfwe = !mr; e.mret = mr;
        end
        e.lat = lat;
        e.instret = exp_instret;
        sbq.push_back(e);
        wait_evt(name, irq_mid);
        if (reach_mem) chk({name, "_lsu_vld_cycles"}, lsu_vld_last, lr + 1);
        $display("txn %-14s trap=%0b cause=%05b pc_ctrl=%0d instret=%0d", name, e.trap, e.cause, e.pc, instret);
    endtask

    task automatic run_irq_trap();
        exp_t e;
        int   v0;
        dec_pc_ctrl = PC_SNPC; dec_is_mem = 0; dec_is_store = 0;
        dec_illegal = 0; dec_ecall = 0; dec_mret = 0;
        e.trap = 1; e.cause = 5'b1_1011; e.pc = PC_TRAP; e.rfwe = 0; e.mret = 0;
        e.lat = 2; e.instret = exp_instret;
        sbq.push_back(e);
        v0 = if_vld_total;
        wait_evt("irq", 1'b0);
        chk("irq_no_fetch", if_vld_total, v0);
        irq_pending = 0; irq_en = 0;
        $display("txn %-14s trap=1 cause=11011 instret=%0d", "irq", instret);
    endtask

    task automatic reset_in_mem_wait();
        int a0, e0;
        dec_pc_ctrl = PC_SNPC; dec_is_mem = 1; dec_is_store = 0;
        dec_illegal = 0; dec_ecall = 0; dec_mret = 0;
        if_rdy_dly = 0; if_rsp_dly = 0; if_err_cfg = 0;
        lsu_rdy_dly = 0; lsu_rsp_dly = 1000; lsu_err_cfg = 0;
        a0 = lsu_acc_cnt;
        for (int i = 0; i < 50 && lsu_acc_cnt == a0; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mem_accepted", {31'd0, lsu_acc_cnt != a0}, 32'd1);
        @(posedge clk); #1;
        rst_n = 0;
        if_rdy_dly = 1000;
        e0 = evt_cnt;
        @(posedge clk); #1;
        check_reset_state("midrst");
        sbq.delete();
        exp_instret = 0;
        rst_n = 1;
        @(posedge clk); #1;
        lsu_rsp_force = 1;
        @(posedge clk); #1;
        lsu_rsp_force = 0;
        repeat (6) begin @(posedge clk); #1; end
        chk("midrst_instret", instret, 32'd0);
        chk("midrst_no_event", evt_cnt, e0);
        chk("midrst_fetch_stall", {31'd0, if_req_valid}, 32'd1);
        chk("midrst_no_lsu", {31'd0, lsu_req_valid}, 32'd0);
        $display("txn %-14s instret=%0d events=%0d", "reset_memwait", instret, evt_cnt - e0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        //        name          pcc       mem st ill ec mr ifr ifd ife lr ld le irq
        run_instr("alu_snpc",   PC_SNPC,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("load_slow",  PC_SNPC,  1, 0, 0, 0, 0, 0, 0, 0, 3, 2, 0, 0);
        run_instr("branch",     PC_B,     0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        run_instr("jalr_irq",   PC_J_RS1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        run_irq_trap();
        run_instr("store_err",  PC_SNPC,  1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        run_instr("load_err",   PC_SNPC,  1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        run_instr("ecall",      PC_SNPC,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("ill_ecall",  PC_SNPC,  1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr("fetch_tmo",  PC_SNPC,  0, 0, 0, 0, 0, 0, 1000, 0, 0, 0, 0, 0);
        run_instr("fetch_late", PC_J_PC,  0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        run_instr("fetch_err",  PC_SNPC,  0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        run_instr("store_tmo",  PC_SNPC,  1, 1, 0, 0, 0, 0, 0, 0, 0, 1000, 0, 0);
        run_instr("load_late",  PC_B_INV, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        for (int k = 0; k < 8; k++) begin
            run_instr("random", 3'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 0, 0, 0, $urandom_range(0, 3),
                      $urandom_range(0, 3), 0, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0);
        end
        reset_in_mem_wait();
        do_reset();
        run_instr("mret",       PC_B,     0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr("alu_after",  PC_SNPC,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        chk("queue_drained", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
